// File: rtl/cpu_pkg.sv
// Shared encodings and widths for the run-state fetch path.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IN    = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b11;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_FETCH_OP = 3'd1,
        FS_FETCH_LO = 3'd2,
        FS_FETCH_HI = 3'd3,
        FS_ISSUE    = 3'd4
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
        return p + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_addr_mux.sv
// Memory bus selection: fetch address during instruction fetch, executor access in ISSUE.
module fetch_addr_mux
    import cpu_pkg::*;
(
    input  fetch_state_e      state_i,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic              ex_read_i,
    input  logic              ex_write_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              read_o,
    output logic              write_o
);

    // Leaving RUN releases the bus in the same cycle so the loaders own memory.
    always_comb begin
        addr_o  = '0;
        read_o  = 1'b0;
        write_o = 1'b0;
        if (run_i) begin
            case (state_i)
                FS_IDLE: begin
                    addr_o = pc_i;
                end
                FS_FETCH_OP, FS_FETCH_LO, FS_FETCH_HI: begin
                    addr_o = pc_i;
                    read_o = 1'b1;
                end
                FS_ISSUE: begin
                    addr_o  = ex_addr_i;
                    write_o = ex_write_i;
                    read_o  = ex_read_i & ~ex_write_i;
                end
                default: begin
                    addr_o = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Run-state instruction fetch: assembles 1/3-byte instructions, issues them,
// then forwards executor data accesses to memory until acknowledged.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          LONG_OP_BIT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cpustate,
    input  logic [7:0]  mem_rdata,
    input  logic [15:0] ex_addr,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic        instr_ack,
    input  logic        jump_valid,
    input  logic [15:0] jump_addr,
    output logic [15:0] addr,
    output logic        read,
    output logic        write,
    output logic [7:0]  ir,
    output logic [15:0] operand,
    output logic        instr_valid,
    output logic [15:0] pc
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] start_q;
    logic [DATA_W-1:0] ir_q;
    logic [15:0]       operand_q;
    logic              valid_q;
    logic              run;

    assign run = (cpustate == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FS_IDLE;
            pc_q      <= RESET_PC;
            start_q   <= RESET_PC;
            ir_q      <= '0;
            operand_q <= '0;
            valid_q   <= 1'b0;
        end else if (!run && state_q != FS_IDLE) begin
            // Rewind to the instruction start so a partial or unacked fetch is replayed.
            state_q <= FS_IDLE;
            valid_q <= 1'b0;
            if (state_q inside {FS_FETCH_LO, FS_FETCH_HI, FS_ISSUE}) begin
                pc_q <= start_q;
            end
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (run) begin
                        state_q <= FS_FETCH_OP;
                    end
                end
                FS_FETCH_OP: begin
                    ir_q      <= mem_rdata;
                    start_q   <= pc_q;
                    pc_q      <= pc_inc(pc_q);
                    operand_q <= '0;
                    if (mem_rdata[LONG_OP_BIT]) begin
                        state_q <= FS_FETCH_LO;
                    end else begin
                        state_q <= FS_ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                FS_FETCH_LO: begin
                    operand_q[7:0] <= mem_rdata;
                    pc_q           <= pc_inc(pc_q);
                    state_q        <= FS_FETCH_HI;
                end
                FS_FETCH_HI: begin
                    operand_q[15:8] <= mem_rdata;
                    pc_q            <= pc_inc(pc_q);
                    state_q         <= FS_ISSUE;
                    valid_q         <= 1'b1;
                end
                FS_ISSUE: begin
                    if (instr_ack) begin
                        valid_q <= 1'b0;
                        state_q <= FS_FETCH_OP;
                        if (jump_valid) begin
                            pc_q <= jump_addr;
                        end
                    end
                end
                default: begin
                    state_q <= FS_IDLE;
                end
            endcase
        end
    end

    fetch_addr_mux u_addr_mux (
        .state_i    (state_q),
        .run_i      (run),
        .pc_i       (pc_q),
        .ex_addr_i  (ex_addr),
        .ex_read_i  (ex_read),
        .ex_write_i (ex_write),
        .addr_o     (addr),
        .read_o     (read),
        .write_o    (write)
    );

    assign ir          = ir_q;
    assign operand     = operand_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a byte-level program model predicts fetch
// addresses and issued instructions; a negedge monitor checks the DUT bus.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cpustate = 2'b11;
    logic [7:0]  mem_rdata;
    logic [15:0] ex_addr = '0;
    logic        ex_read = 1'b0;
    logic        ex_write = 1'b0;
    logic        instr_ack = 1'b0;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [15:0] addr;
    logic        read;
    logic        write;
    logic [7:0]  ir;
    logic [15:0] operand;
    logic        instr_valid;
    logic [15:0] pc;

    typedef struct {
        logic [7:0]  ir;
        logic [15:0] operand;
        logic [15:0] pc;
    } instr_t;

    logic [7:0]  mem [0:65535];
    instr_t      exp_instr[$];
    logic [15:0] exp_fetch[$];
    instr_t      mon_e;
    logic        prev_valid = 1'b0;
    logic [15:0] mpc;
    int          checks_total = 0;
    int          checks_passed = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem[addr];

    fetch_unit #(.RESET_PC(16'h0000), .LONG_OP_BIT(7)) dut (
        .clk(clk), .reset(reset), .cpustate(cpustate), .mem_rdata(mem_rdata),
        .ex_addr(ex_addr), .ex_read(ex_read), .ex_write(ex_write),
        .instr_ack(instr_ack), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .addr(addr), .read(read), .write(write), .ir(ir), .operand(operand),
        .instr_valid(instr_valid), .pc(pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: an instruction at s is 1 byte, or 3 bytes when opcode bit 7 is set.
    task automatic model_instr(input logic [15:0] s, output logic [15:0] nxt, output int lat);
        instr_t e;
        logic [15:0] a1, a2;
        a1 = s + 16'd1;
        a2 = s + 16'd2;
        e.ir = mem[s];
        exp_fetch.push_back(s);
        if (e.ir[7]) begin
            exp_fetch.push_back(a1);
            exp_fetch.push_back(a2);
            e.operand = {mem[a2], mem[a1]};
            nxt = s + 16'd3;
            lat = 3;
        end else begin
            e.operand = 16'h0000;
            nxt = a1;
            lat = 1;
        end
        e.pc = nxt;
        exp_instr.push_back(e);
    endtask

    // Waits for instr_valid; meanwhile drives stray acks/jumps that must be ignored.
    task automatic wait_valid(output int n);
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            ok = instr_valid;
            if (!ok) begin
                instr_ack  = 1'($urandom_range(0, 1));
                jump_valid = 1'($urandom_range(0, 1));
                jump_addr  = 16'($urandom);
                ex_addr    = 16'($urandom);
                ex_read    = 1'($urandom_range(0, 1));
                ex_write   = 1'($urandom_range(0, 1));
            end
        end
        instr_ack  = 1'b0;
        jump_valid = 1'b0;
        if (!ok) begin
            checks_total++;
            $display("FAIL wait_valid: instr_valid=%b after %0d cycles, required 1", instr_valid, n);
        end
    endtask

    task automatic do_ack(input bit jmp, input logic [15:0] tgt, output int lat);
        logic [15:0] s;
        s = jmp ? tgt : mpc;
        model_instr(s, mpc, lat);
        instr_ack  = 1'b1;
        jump_valid = jmp;
        jump_addr  = jmp ? tgt : 16'($urandom);
        @(posedge clk);
        #1;
        instr_ack  = 1'b0;
        jump_valid = 1'b0;
    endtask

    task automatic ex_phase();
        int k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            ex_addr    = 16'($urandom);
            ex_read    = 1'($urandom_range(0, 1));
            ex_write   = 1'($urandom_range(0, 1));
            jump_valid = 1'($urandom_range(0, 1));
            jump_addr  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        jump_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (instr_valid && !prev_valid) begin
                if (exp_instr.size() == 0) begin
                    checks_total++;
                    $display("FAIL instr_unexpected: got ir=%h operand=%h pc=%h, required none", ir, operand, pc);
                end else begin
                    mon_e = exp_instr.pop_front();
                    check("ir", {24'd0, ir}, {24'd0, mon_e.ir});
                    check("operand", {16'd0, operand}, {16'd0, mon_e.operand});
                    check("pc_after", {16'd0, pc}, {16'd0, mon_e.pc});
                end
            end
            if (cpustate != 2'b11) begin
                check("bus_released", {14'd0, addr, read, write}, 32'd0);
            end else if (instr_valid) begin
                check("ex_bus", {14'd0, addr, read, write},
                      {14'd0, ex_addr, ex_read & ~ex_write, ex_write});
            end else if (read || write) begin
                if (exp_fetch.size() == 0) begin
                    checks_total++;
                    $display("FAIL fetch_unexpected: got addr=%h read=%b, required no access", addr, read);
                end else begin
                    check("fetch_addr", {14'd0, addr, read, write}, {14'd0, exp_fetch.pop_front(), 2'b10});
                end
            end
            prev_valid <= instr_valid;
        end
    end

    initial begin
        int n, lat;
        bit jmp;
        logic [15:0] tgt;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h05;
        mem[16'h0001] = 8'h83;
        mem[16'h0002] = 8'h34;
        mem[16'h0003] = 8'h12;
        mem[16'hFFFF] = 8'h01;
        mem[16'h0008] = 8'h85;

        #1 reset = 1'b1;
        #2;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_ir", {24'd0, ir}, 32'd0);
        check("rst_operand", {16'd0, operand}, 32'd0);
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_bus", {14'd0, addr, read, write}, 32'd0);

        model_instr(16'h0000, mpc, lat);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_valid(n);
        check("lat_from_idle", n, lat + 1);

        do_ack(1'b0, 16'h0000, lat);
        wait_valid(n);
        check("lat_long", n, lat);

        ex_addr = 16'h0040; ex_write = 1'b1; ex_read = 1'b1;
        @(posedge clk);
        #1;
        do_ack(1'b1, 16'h0010, lat);
        wait_valid(n);
        check("lat_jump", n, lat);

        for (int it = 0; it < 40; it++) begin
            ex_phase();
            jmp = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: tgt = 16'hFFFF;
                1: tgt = 16'hFFFE;
                2: tgt = 16'h001F;
                3: tgt = 16'h001E;
                default: tgt = 16'($urandom);
            endcase
            do_ack(jmp, tgt, lat);
            wait_valid(n);
            check("lat_rand", n, lat);
        end

        do_ack(1'b1, 16'hFFFF, lat);
        wait_valid(n);
        check("lat_wrap", n, lat);
        do_ack(1'b0, 16'h0000, lat);
        wait_valid(n);
        check("lat_after_wrap", n, lat);

        // Abort during FETCH_HI of a 3-byte instruction at 0x0008.
        do_ack(1'b1, 16'h0008, lat);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 cpustate = 2'b10;
        #1;
        check("abort_read_now", {31'd0, read}, 32'd0);
        check("abort_pending_fetch", exp_fetch.size(), 1);
        @(posedge clk);
        #1;
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        check("abort_pc", {16'd0, pc}, 32'h0008);
        exp_fetch.delete();
        exp_instr.delete();
        repeat (2) @(posedge clk);
        #1 cpustate = 2'b11;
        model_instr(16'h0008, mpc, lat);
        wait_valid(n);
        check("lat_refetch", n, lat + 1);

        ex_addr = 16'h1234; ex_read = 1'b1; ex_write = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_issue_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_issue_pc", {16'd0, pc}, 32'd0);
        check("rst_issue_bus", {14'd0, addr, read, write}, 32'd0);
        exp_fetch.delete();
        exp_instr.delete();
        model_instr(16'h0000, mpc, lat);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_valid(n);
        check("lat_after_reset", n, lat + 1);

        @(negedge clk);
        #1;
        check("fetch_queue_drained", exp_fetch.size(), 0);
        check("instr_queue_drained", exp_instr.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Run-state instruction fetch and memory-bus master; sits directly upstream of the program/data memory.
- Drives the memory's 16-bit address bus and its read/write strobes.
- Assembles 1-byte or 3-byte instructions from the memory's 8-bit read data.
- Hands each completed instruction to the executor; once the instruction is issued, passes the executor's data accesses through to memory.

Parameters:
RESET_PC, 16'h0000, pc value after reset
LONG_OP_BIT, 7, opcode bit index; when set, the instruction carries a 16-bit operand

Ports:
clk  input  1  system clock (divided clock, same as memory)
reset  input  1  asynchronous, active-high reset
cpustate  input  2  01=IN, 10=CHECK, 11=RUN; unit active only in RUN
mem_rdata  input  8  memory read data
ex_addr  input  16  executor data address, used in ISSUE only
ex_read  input  1  executor read request, used in ISSUE only
ex_write  input  1  executor write request, used in ISSUE only
instr_ack  input  1  executor consumed current instruction
jump_valid  input  1  redirect pc, sampled only with instr_ack
jump_addr  input  16  redirect target
addr  output  16  memory address
read  output  1  memory read strobe
write  output  1  memory write strobe
ir  output  8  current opcode
operand  output  16  {hi,lo} operand bytes; 0 for 1-byte instructions
instr_valid  output  1  ir/operand valid
pc  output  16  address of next byte to fetch

Behaviour:
- Reset (async, active-high):
  - State IDLE; pc=RESET_PC; instr_start=RESET_PC.
  - ir=0, operand=0, instr_valid=0, addr=0, read=0, write=0.
- Memory timing: addr/read are presented during a cycle; mem_rdata is sampled on the rising edge that ends that cycle.
- States: IDLE, FETCH_OP, FETCH_LO, FETCH_HI, ISSUE.
- IDLE:
  - read=0, write=0, addr=pc.
  - When cpustate==11, next state is FETCH_OP.
- FETCH_OP:
  - addr=pc, read=1.
  - At edge: ir<=mem_rdata, instr_start<=pc, pc<=pc+1, operand<=0.
  - If mem_rdata[LONG_OP_BIT]=1, next state is FETCH_LO; otherwise ISSUE.
- FETCH_LO:
  - addr=pc, read=1.
  - At edge: operand[7:0]<=mem_rdata, pc<=pc+1, next state FETCH_HI.
- FETCH_HI:
  - addr=pc, read=1.
  - At edge: operand[15:8]<=mem_rdata, pc<=pc+1, next state ISSUE.
- ISSUE:
  - instr_valid=1 (registered; rises on the edge entering ISSUE).
  - addr=ex_addr.
  - write=ex_write; read=ex_read & ~ex_write (write wins on a simultaneous request).
  - ir/operand stay stable while instr_valid=1.
- instr_ack in ISSUE:
  - instr_valid<=0; next state FETCH_OP.
  - If jump_valid, pc<=jump_addr; otherwise pc is unchanged.
  - jump_valid without instr_ack is ignored.
  - instr_ack outside ISSUE is ignored.
- Latency: ISSUE is entered 1 cycle after FETCH_OP for a 1-byte instruction and 3 cycles after for a 3-byte instruction. Ack-to-next-fetch is 0 cycles: FETCH_OP occupies the cycle after the ack edge.
- pc arithmetic is 16-bit modulo: FFFF+1 = 0000. Crossing the memory's internal region boundary (0x001F to 0x0020) needs no special handling.
- cpustate leaving 11 in any non-IDLE state:
  - Next edge: state IDLE, instr_valid<=0, read/write forced 0 combinationally in that same cycle.
  - If abort occurs in FETCH_LO/FETCH_HI/ISSUE, pc<=instr_start so the partial or unacked instruction is refetched on re-entry.
  - Abort in FETCH_OP leaves pc unchanged.
- Outside RUN, addr/read/write never assert, so the IN/CHECK loaders own memory.
- Reset mid-instruction: immediate return to reset values; no partial state retained.

Decomposition:
- Shared package cpu_pkg:
  - cpustate encodings: ST_IN=2'b01, ST_CHECK=2'b10, ST_RUN=2'b11.
  - FSM state typedef/localparams.
  - Constant ADDR_W=16, DATA_W=8.
- One natural sub-module: fetch_addr_mux, the combinational selection of addr/read/write by state.
- pc/FSM logic stays in fetch_unit.

Test Plan:
- Reset with cpustate=11, memory[0]=8'h05 -> FETCH_OP at 0x0000, read=1; next cycle instr_valid=1, ir=05, operand=0000, pc=0001.
- memory[0..2]=8'h83,8'h34,8'h12 -> three read cycles at addrs 0,1,2; ISSUE with ir=83, operand=1234, pc=0003.
- In ISSUE, ex_addr=0x0040, ex_write=1, ex_read=1 -> addr=0040, write=1, read=0; then ack with jump_valid=1, jump_addr=0x0010 -> next fetch at addr 0010.
- pc=FFFF, opcode 0x01 at FFFF -> after fetch pc=0000; next FETCH_OP addr=0000.
- cpustate drops to 10 during FETCH_HI of an instruction starting at 0x0008 -> read=0 immediately, IDLE, instr_valid=0, pc=0008; return to 11 -> refetch starts at 0008.
- Assert reset during ISSUE with instr_valid=1 -> same-cycle instr_valid=0, pc=0000, addr=0, read=write=0.
